// File: rtl/shiftreg_timer_pkg.sv
// Shared state encoding and default parameters for the shift-register timer controller.
package shiftreg_timer_pkg;

    localparam int unsigned SHIFT_LEN_DEF   = 4;
    localparam int unsigned ACK_TIMEOUT_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        S1,
        S11,
        S110,
        SHIFT,
        COUNT,
        DONE
    } state_t;

endpackage

// File: rtl/shiftreg_pattern_det.sv
// Overlapping 1101 start-pattern detector; found pulses in the cycle the final 1 is presented.
module shiftreg_pattern_det
    import shiftreg_timer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic found
);

    state_t st;
    state_t st_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
        end else begin
            st <= st_nx;
        end
    end

    // Held in IDLE while the top FSM is busy, so each search starts from scratch.
    always_comb begin
        st_nx = st;
        found = 1'b0;
        if (!en) begin
            st_nx = IDLE;
        end else begin
            case (st)
                IDLE:    st_nx = d ? S1 : IDLE;
                S1:      st_nx = d ? S11 : IDLE;
                S11:     st_nx = d ? S11 : S110;
                S110: begin
                    st_nx = IDLE;
                    found = d;
                end
                default: st_nx = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/shiftreg_timer_ctrl.sv
// Timer controller: detects 1101, shifts SHIFT_LEN cycles, counts, then waits for ack.
// Define SHIFTREG_TIMER_ACK_TIMEOUT_EN to abandon DONE after ACK_TIMEOUT cycles without ack.
module shiftreg_timer_ctrl
    import shiftreg_timer_pkg::*;
#(
    parameter int unsigned SHIFT_LEN   = SHIFT_LEN_DEF,
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic done_counting,
    input  logic ack,
    output logic shift_ena,
    output logic count_ena,
    output logic done
);

    localparam int unsigned CW = $clog2(SHIFT_LEN);
    localparam logic [CW-1:0] SLAST = CW'(SHIFT_LEN - 1);

    if (SHIFT_LEN < 2 || SHIFT_LEN > 16 || ACK_TIMEOUT < 1) begin : g_param_check
        $error("shiftreg_timer_ctrl: SHIFT_LEN must be 2..16 and ACK_TIMEOUT >= 1");
    end

    // IDLE stands for the whole search; its sub-states live in the detector.
    state_t        st;
    state_t        st_nx;
    logic [CW-1:0] scnt;
    logic          found;
    logic          tmo;

    shiftreg_pattern_det u_det (
        .clk   (clk),
        .rst   (rst),
        .en    (st == IDLE),
        .d     (d),
        .found (found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
        end else begin
            st <= st_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt <= '0;
        end else if (st == SHIFT && scnt != SLAST) begin
            scnt <= scnt + CW'(1);
        end else begin
            scnt <= '0;
        end
    end

`ifdef SHIFTREG_TIMER_ACK_TIMEOUT_EN
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(ACK_TIMEOUT - 1);

    logic [TW-1:0] tcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (st == DONE) begin
            tcnt <= tcnt + TW'(1);
        end else begin
            tcnt <= '0;
        end
    end

    assign tmo = (st == DONE) && (tcnt == TLAST);
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        st_nx = st;
        case (st)
            IDLE:    if (found) st_nx = SHIFT;
            SHIFT:   if (scnt == SLAST) st_nx = COUNT;
            COUNT:   if (done_counting) st_nx = DONE;
            DONE:    if (ack || tmo) st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    always_comb begin
        shift_ena = (st == SHIFT);
        count_ena = (st == COUNT);
        done      = (st == DONE);
    end

endmodule

// File: tb/tb_shiftreg_timer_ctrl.sv
// Self-checking bench: directed sequences plus randomized traffic against a behavioural model.
module tb_shiftreg_timer_ctrl;

    localparam int SL = 4;
    localparam int AT = 16;

    logic clk = 1'b0;
    logic rst;
    logic d;
    logic done_counting;
    logic ack;
    logic shift_ena;
    logic count_ena;
    logic done;

    int checks = 0;
    int passes = 0;

    // Model: phase 0 search, 1 shift, 2 count, 3 done; search keeps the last four bits seen.
    int         ph;
    logic [3:0] hist;
    int         nbits;
    int         left;
    int         dwait;

    always #5 clk = ~clk;

    shiftreg_timer_ctrl #(
        .SHIFT_LEN   (SL),
        .ACK_TIMEOUT (AT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .d             (d),
        .done_counting (done_counting),
        .ack           (ack),
        .shift_ena     (shift_ena),
        .count_ena     (count_ena),
        .done          (done)
    );

    function automatic logic [2:0] mexp();
        return {ph == 1, ph == 2, ph == 3};
    endfunction

    function automatic logic [2:0] outs();
        return {shift_ena, count_ena, done};
    endfunction

    task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: shift/count/done got %b expected %b at %0t", nm, got, exp, $time);
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    endtask

    task automatic model_reset();
        ph = 0; hist = '0; nbits = 0; left = 0; dwait = 0;
    endtask

    task automatic model_step(input logic di, input logic dci, input logic acki);
        case (ph)
            0: begin
                hist = {hist[2:0], di};
                nbits++;
                if (nbits >= 4 && hist == 4'b1101) begin
                    ph = 1; left = SL; hist = '0; nbits = 0;
                end
            end
            1: begin
                left--;
                if (left == 0) ph = 2;
            end
            2: if (dci) begin ph = 3; dwait = 0; end
            default: begin
                dwait++;
                if (acki) ph = 0;
`ifdef SHIFTREG_TIMER_ACK_TIMEOUT_EN
                else if (dwait == AT) ph = 0;
`endif
                if (ph == 0) begin hist = '0; nbits = 0; end
            end
        endcase
    endtask

    // Apply inputs for the coming edge, advance the model, compare after the edge.
    task automatic step(input logic di, input logic dci, input logic acki);
        d = di; done_counting = dci; ack = acki;
        model_step(di, dci, acki);
        @(negedge clk);
        chk("model", outs(), mexp());
    endtask

    task automatic async_reset();
        d = 1'b0; done_counting = 1'b0; ack = 1'b0;
        model_step(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 model_reset();
        chk("async_rst", outs(), 3'b000);
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst", outs(), mexp());
    endtask

    task automatic bits(input logic [7:0] v, input int n);
        logic [7:0] t;
        t = v;
        for (int i = n - 1; i >= 0; i--) step(t[i], 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; d = 1'b0; done_counting = 1'b0; ack = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset", outs(), 3'b000);
        rst = 1'b0;

        // 1101, control inputs ignored during shift, 7-cycle count, ack.
        bits(8'b110, 3);
        chk("pre_detect", outs(), 3'b000);
        step(1'b1, 1'b0, 1'b0);
        chk("shift_start", outs(), 3'b100);
        step(1'b0, 1'b1, 1'b1);
        chk("shift_ignores", outs(), 3'b100);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("shift_4th", outs(), 3'b100);
        step(1'b0, 1'b0, 1'b1);
        chk("count_nogap", outs(), 3'b010);
        for (int i = 0; i < 6; i++) step(1'($urandom), 1'b0, 1'($urandom));
        chk("count_7th", outs(), 3'b010);
        step(1'b0, 1'b1, 1'b0);
        chk("done_set", outs(), 3'b001);
        step(1'b1, 1'b1, 1'b1);
        chk("ack_idle", outs(), 3'b000);

        // Overlapping 11101, then async reset in the second shift cycle.
        bits(8'b1110, 4);
        chk("ovl_pre", outs(), 3'b000);
        step(1'b1, 1'b0, 1'b0);
        chk("ovl_hit", outs(), 3'b100);
        async_reset();

        bits(8'b1100110, 7);
        chk("late_pre", outs(), 3'b000);
        step(1'b1, 1'b0, 1'b0);
        chk("late_hit", outs(), 3'b100);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        chk("restart_count", outs(), 3'b010);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // DONE without ack.
        bits(8'b1101, 4);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("done_entry", outs(), 3'b001);
        n = 1;
        for (int i = 0; i < 150 && done === 1'b1; i++) begin
            step(1'($urandom), 1'($urandom), 1'b0);
            if (done === 1'b1) n++;
        end
`ifdef SHIFTREG_TIMER_ACK_TIMEOUT_EN
        chk_int("timeout_len", n, AT);
`else
        chk_int("no_timeout", int'(n >= 100), 1);
`endif
        if (done === 1'b1) step(1'b0, 1'b0, 1'b1);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(199) == 0) async_reset();
            else step(1'($urandom), ($urandom_range(7) == 0), ($urandom_range(4) == 0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/shiftreg_timer_ctrl.md
SHIFTREG_TIMER_CTRL -- requirements
Module: shiftreg_timer_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are named clk and rst.
REQ-002 Parameter SHALL be: SHIFT_LEN, 4, number of cycles shift_ena is held high (equals downstream shift register width, 2..16).
REQ-003 Parameter SHALL be: ACK_TIMEOUT, 16, cycles to wait in DONE before abandoning (used only with REQ-024).
REQ-004 Port SHALL be: clk  input  1  rising-edge clock.
REQ-005 Port SHALL be: rst  input  1  asynchronous active-high reset.
REQ-006 Port SHALL be: d  input  1  serial data; carries start pattern, then delay bits for the downstream shift register.
REQ-007 Port SHALL be: done_counting  input  1  high when the downstream down counter has reached zero.
REQ-008 Port SHALL be: ack  input  1  user acknowledge of done.
REQ-009 Port SHALL be: shift_ena  output  1  shift enable to the downstream shift register/counter.
REQ-010 Port SHALL be: count_ena  output  1  count enable to the downstream shift register/counter.
REQ-011 Port SHALL be: done  output  1  timer expired, waiting for ack.

Function
REQ-012 The block SHALL be a Moore FSM with states IDLE, S1, S11, S110, SHIFT, COUNT, DONE; all outputs decode from registered state only.
REQ-013 Pattern detection SHALL follow: IDLE -d=1-> S1; S1 -d=1-> S11, else IDLE; S11 -d=0-> S110, d=1 stays S11; S110 -d=1-> SHIFT, else IDLE.
REQ-014 Detection SHALL be overlapping within the search: 1,1,1,0,1 is detected at the fifth bit.
REQ-015 In SHIFT, shift_ena SHALL be 1 for exactly SHIFT_LEN consecutive cycles, starting the cycle after the final pattern bit is sampled; a ceil(log2(SHIFT_LEN))-bit counter tracks this.
REQ-016 After the last SHIFT cycle the FSM SHALL enter COUNT unconditionally, with no gap cycle.
REQ-017 In COUNT, count_ena SHALL be 1; when done_counting is sampled 1 at a rising edge the FSM SHALL go to DONE, so count_ena drops in the next cycle.
REQ-018 In DONE, done SHALL be 1; when ack is sampled 1 the FSM SHALL go to IDLE and restart detection from scratch.
REQ-019 d SHALL be ignored outside the detect states; done_counting SHALL be ignored outside COUNT; ack SHALL be ignored outside DONE.
REQ-020 shift_ena, count_ena and done SHALL be mutually exclusive; all are 0 in the detect states.

Reset
REQ-021 On rst=1 the state SHALL go immediately to IDLE, the shift counter to 0, and shift_ena, count_ena and done to 0, independent of clk.
REQ-022 Reset asserted mid-SHIFT, mid-COUNT or in DONE SHALL abort the operation with no residual enable pulse; detection restarts on the first edge after release.

Configuration
REQ-023 The macro SHIFTREG_TIMER_ACK_TIMEOUT_EN SHALL select the ack timeout feature.
REQ-024 With the macro defined, a DONE-state counter SHALL return the FSM to IDLE after ACK_TIMEOUT cycles without ack; ack in the same cycle as expiry takes precedence (same result). Without the macro, DONE SHALL wait indefinitely and no timeout logic is built.

Structure
REQ-025 The state encoding localparams and the default SHIFT_LEN/ACK_TIMEOUT constants SHALL live in the shared package/include shiftreg_timer_pkg.
REQ-026 The 1101 detector (IDLE..S110 transitions) SHALL be one sub-module, shiftreg_pattern_det, that pulses found for one cycle; the top FSM owns SHIFT/COUNT/DONE.

Verification
REQ-027 d=1,1,0,1 after reset, SHIFT_LEN=4 -> shift_ena high exactly 4 cycles starting the edge after the 4th bit, then count_ena high with no gap.
REQ-028 d=1,1,1,0,1 -> detected at 5th bit; d=1,1,0,0,1,1,0,1 -> detected only at the 8th bit.
REQ-029 In COUNT, done_counting=1 after 7 cycles -> count_ena high 7 cycles, done=1 next cycle; ack=1 for 1 cycle -> done=0, state IDLE.
REQ-030 ack=1 and done_counting=1 pulsed during SHIFT -> no effect; shift_ena still exactly 4 cycles.
REQ-031 rst=1 asynchronously at 2nd SHIFT cycle -> all outputs 0 before the next edge; a fresh 1101 restarts the full sequence.
REQ-032 With SHIFTREG_TIMER_ACK_TIMEOUT_EN, ACK_TIMEOUT=16, no ack -> done high exactly 16 cycles then IDLE; without the macro done stays high for 100+ cycles.
